recip_arbiter: RTL and testbench

Shares one fpdiv_clk_acc reciprocal unit (1/x, sign-magnitude Q15.16) among NREQ requesters, for example the LSP, energy and pitch-gain paths of codec2_encode_2400. It runs round-robin arbitration, latches the winner's operand and sequences the divider's startdiv/donediv handshake. It intercepts zero operands, which would hang the divider's normalisation loop. A watchdog recovers the divider if donediv never arrives.

---
 rtl/codec2_pkg.sv | 24 ++
 rtl/recip_arbiter_rr_pick.sv | 35 +++
 rtl/recip_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_recip_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec2_pkg.sv
// Shared definitions for the codec2 fixed-point datapath blocks:
// sign-magnitude Q15.16 constants and the reciprocal arbiter state encoding.
package codec2_pkg;

    localparam int N = 32;
    localparam int Q = 16;

    // 1.0 in sign-magnitude Q15.16.
    localparam logic [N-1:0] ONE = 32'h0001_0000;
    // Largest representable magnitude, used for saturated results.
    localparam logic [N-2:0] SAT_MAG = '1;

    // Watchdog counter width.
    localparam int WD_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/recip_arbiter_rr_pick.sv
// Combinational round-robin priority picker: the first set request bit
// found when searching ptr, ptr+1, ... (mod NREQ) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            hit
);
    import codec2_pkg::*;

    // Rotating search starting at ptr; the first hit locks the choice.
    always_comb begin
        int k;
        logic [IW-1:0] kk;
        win     = '0;
        win_idx = '0;
        hit     = 1'b0;
        k       = 0;
        kk      = '0;
        for (int i = 0; i < NREQ; i++) begin
            k  = (int'(ptr) + i) % NREQ;
            kk = IW'(k);
            if (!hit && req[kk]) begin
                hit     = 1'b1;
                win[kk] = 1'b1;
                win_idx = kk;
            end
        end
    end

endmodule

// File: rtl/recip_arbiter.sv
// Shares one reciprocal divider among NREQ requesters. Round-robin grant,
// operand capture, startdiv/donediv sequencing, zero-operand bypass and a
// watchdog that resets the divider when donediv never arrives.
//
// Handshake: req[k] is held high (operand stable) until ack[k] pulses for one
// cycle; result/err are valid in that ack cycle. The divider gets a one-cycle
// div_start with div_in stable, and answers with a one-cycle div_done.
module recip_arbiter #(
    parameter int NREQ    = 4,
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int TIMEOUT = 511
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] operand,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [N-1:0]      result,
    output logic              err,
    output logic              busy,
    output logic              div_start,
    output logic [N-1:0]      div_in,
    input  logic [N-1:0]      div_ans,
    input  logic              div_done,
    output logic              div_rst_n
);
    import codec2_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    // Q only fixes where the binary point sits; it must leave room for the sign.
    if (Q >= N) begin : g_bad_q
        $error("recip_arbiter: Q must be smaller than N");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_idx_q, win_idx_d;
    logic [N-1:0]    op_q, op_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            abort_n_q, abort_n_d;
    logic            abort_cnt_q, abort_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [N-1:0]    result_q, result_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            div_start_q, div_start_d;
    logic [N-1:0]    div_in_q, div_in_d;

    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            pick_hit;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .hit     (pick_hit)
    );

    // Next-state and registered-output logic for the arbitration sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_idx_d   = win_idx_q;
        op_d        = op_q;
        wd_d        = wd_q;
        abort_n_d   = abort_n_q;
        abort_cnt_d = abort_cnt_q;
        gnt_d       = gnt_q;
        result_d    = result_q;
        err_d       = err_q;
        div_start_d = 1'b0;
        div_in_d    = div_in_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_hit) begin
                    op_d      = operand[pick_idx*N +: N];
                    gnt_d     = pick_win;
                    win_idx_d = pick_idx;
                    state_d   = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // A zero magnitude (either sign) would hang the divider's
                // normalisation loop, so it is answered directly.
                if (op_q[N-2:0] == '0) begin
                    result_d = {op_q[N-1], {(N-1){1'b1}}};
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    div_in_d    = op_q;
                    div_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_done) begin
                    result_d = div_ans;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (wd_q == WD_LIMIT) begin
                    abort_n_d   = 1'b0;
                    abort_cnt_d = 1'b0;
                    state_d     = ST_ABORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                // Divider reset is held for two full cycles.
                if (abort_cnt_q) begin
                    abort_n_d = 1'b1;
                    result_d  = {op_q[N-1], {(N-1){1'b1}}};
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    abort_cnt_d = 1'b1;
                end
            end
            ST_RESP: begin
                gnt_d   = '0;
                ptr_d   = (win_idx_q == IW'(NREQ - 1)) ? '0 : win_idx_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // ack and busy follow the state being entered so they line up with it.
        ack_d  = (state_d == ST_RESP) ? gnt_d : '0;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_idx_q   <= '0;
            op_q        <= '0;
            wd_q        <= '0;
            abort_n_q   <= 1'b1;
            abort_cnt_q <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            div_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_idx_q   <= win_idx_d;
            op_q        <= op_d;
            wd_q        <= wd_d;
            abort_n_q   <= abort_n_d;
            abort_cnt_q <= abort_cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            div_start_q <= div_start_d;
            div_in_q    <= div_in_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign div_start = div_start_q;
    assign div_in    = div_in_q;
    // Both terms are flop outputs or the reset pin, so the AND cannot glitch.
    assign div_rst_n = rst & abort_n_q;

endmodule

// File: tb/tb_recip_arbiter.sv
// Bench for recip_arbiter: behavioural divider, a transaction-level model of
// the arbiter checked every cycle, and directed scenarios with literal results.
module tb_recip_arbiter;
  import codec2_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 511;
  localparam int DIV_LAT = 6;
  localparam logic [31:0] SAT_POS = {1'b0, SAT_MAG};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] operand = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic [N-1:0]      result, div_in, div_ans;
  logic              err, busy, div_start, div_done, div_rst_n;

  recip_arbiter #(.NREQ(NREQ), .N(N), .Q(Q), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .operand(operand), .gnt(gnt), .ack(ack),
    .result(result), .err(err), .busy(busy), .div_start(div_start),
    .div_in(div_in), .div_ans(div_ans), .div_done(div_done), .div_rst_n(div_rst_n)
  );

  int total = 0;
  int bad = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Reciprocal of a sign-magnitude Q15.16 value: 1/(m/2^16) in Q16 = 2^32/m.
  function automatic logic [31:0] recip(input logic [31:0] x);
    logic [63:0] qt;
    qt = 64'h1_0000_0000 / {33'd0, x[30:0]};
    return {x[31], qt[30:0]};
  endfunction

  // ---------------- behavioural divider ----------------
  bit stub = 0;
  bit spur = 0;
  int d_cnt = 0;
  logic [31:0] d_op = '0;
  int start_cnt = 0;
  int rstn_low_cnt = 0;
  initial begin
    div_done = 1'b0;
    div_ans  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (div_start === 1'b1) start_cnt++;
      if (rst === 1'b1 && div_rst_n === 1'b0) rstn_low_cnt++;
      if (div_rst_n !== 1'b1) begin
        d_cnt = 0;
      end else begin
        if (d_cnt != 0) begin
          d_cnt--;
          if (d_cnt == 0) begin
            div_done = 1'b1;
            div_ans  = recip(d_op);
          end
        end
        if (div_start === 1'b1 && !stub) begin
          d_op  = div_in;
          d_cnt = DIV_LAT;
        end
      end
      if (spur) begin
        div_done = 1'b1;
        spur = 0;
      end
    end
  end

  // ---------------- arbiter model ----------------
  logic [NREQ-1:0] exp_gnt, exp_ack;
  logic [31:0] exp_result, exp_div_in;
  logic exp_err, exp_busy, exp_div_start, exp_abort_n;
  int m_ptr;
  int gen = 0;

  task automatic reset_expect();
    exp_gnt = '0; exp_ack = '0; exp_result = '0; exp_err = 1'b0;
    exp_busy = 1'b0; exp_div_start = 1'b0; exp_div_in = '0; exp_abort_n = 1'b1;
    m_ptr = 0;
  endtask

  // One transaction, from the IDLE edge that granted w to the end of its ack.
  task automatic serve(input int w, input logic [31:0] op);
    int g;
    int cnt;
    logic [NREQ-1:0] oh;
    g = gen;
    oh = '0;
    oh[w] = 1'b1;
    exp_gnt = oh; exp_busy = 1'b1;
    @(posedge clk); if (gen != g) return;
    if (op[30:0] == 31'd0) begin
      exp_result = {op[31], SAT_MAG}; exp_err = 1'b1;
    end else begin
      exp_div_start = 1'b1; exp_div_in = op;
      cnt = 0;
      forever begin
        @(posedge clk); if (gen != g) return;
        exp_div_start = 1'b0;
        if (div_done === 1'b1) begin
          exp_result = recip(op); exp_err = 1'b0;
          break;
        end
        if (cnt == TIMEOUT) begin
          exp_abort_n = 1'b0;
          @(posedge clk); if (gen != g) return;
          @(posedge clk); if (gen != g) return;
          exp_abort_n = 1'b1; exp_result = {op[31], SAT_MAG}; exp_err = 1'b1;
          break;
        end
        cnt++;
      end
    end
    exp_ack = oh;
    @(posedge clk); if (gen != g) return;
    exp_ack = '0; exp_gnt = '0; exp_busy = 1'b0;
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    reset_expect();
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) continue;
      if (req != '0) begin
        int w;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
        end
        serve(w, operand[w*N +: N]);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("result", 64'(result), 64'(exp_result));
      chk("err", 64'(err), 64'(exp_err));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("div_start", 64'(div_start), 64'(exp_div_start));
      chk("div_in", 64'(div_in), 64'(exp_div_in));
      chk("div_rst_n", 64'(div_rst_n), 64'(rst & exp_abort_n));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise(input int k, input logic [31:0] op);
    operand[k*N +: N] = op;
    req[k] = 1'b1;
  endtask

  task automatic assert_rst();
    rst = 1'b0;
    gen++;
    reset_expect();
  endtask

  task automatic wait_ack(output int idx, output logic [31:0] res, output logic e, output int cyc);
    idx = -1; res = '0; e = 1'b0; cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        for (int k = 0; k < NREQ; k++) if (ack[k]) idx = k;
        res = result; e = err;
        req[idx] = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL ack_timeout act=none exp=ack t=%0t", $time);
  endtask

  // Waits for the next ack and checks it against literal expectations.
  task automatic expect_ack(input string nm, input int k, input logic e, output int cyc);
    int idx;
    logic [31:0] res;
    logic ee;
    logic [31:0] want;
    wait_ack(idx, res, ee, cyc);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
    chk({nm, "_idx"}, 64'(idx), 64'(k));
    chk({nm, "_res"}, 64'(res), 64'(want));
    chk({nm, "_err"}, 64'(ee), 64'(e));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc, idx, diff;
    logic [31:0] res;
    logic e;
    rst = 1'b1;
    #1 assert_rst();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_div_rst_n", 64'(div_rst_n), 64'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_div_rst_n", 64'(div_rst_n), 64'd1);
    chk("post_rst_result", 64'(result), 64'd0);

    // Two requesters from reset, then req[0] re-raised: ptr=1 must pick 2.
    raise(0, 32'h0002_0000);
    raise(2, 32'h0000_8000);
    exp_q.push_back(32'h0000_8000);
    expect_ack("rr_first", 0, 1'b0, cyc);
    raise(0, 32'h0002_0000);
    exp_q.push_back(32'h0002_0000);
    expect_ack("rr_skip", 2, 1'b0, cyc);
    exp_q.push_back(32'h0000_8000);
    expect_ack("rr_back", 0, 1'b0, cyc);

    // 4.0 -> 0.25 through the divider, one start pulse.
    @(negedge clk);
    start_cnt = 0;
    raise(1, 32'h0004_0000);
    wait_ack(idx, res, e, cyc);
    diff = (res > 32'h4000) ? int'(res - 32'h4000) : int'(32'h4000 - res);
    chk("four_idx", 64'(idx), 64'd1);
    chk("four_near", 64'(diff <= 2), 64'd1);
    chk("four_err", 64'(e), 64'd0);
    chk("four_starts", 64'(start_cnt), 64'd1);

    // Negative zero: saturated, no divider start, ack in the third cycle.
    @(negedge clk);
    start_cnt = 0;
    raise(3, 32'h8000_0000);
    exp_q.push_back(32'hFFFF_FFFF);
    expect_ack("negzero", 3, 1'b1, cyc);
    chk("negzero_latency", 64'(cyc), 64'd2);
    chk("negzero_starts", 64'(start_cnt), 64'd0);

    // -2.0 -> -0.5, sign from the divider; ptr wrapped to 0.
    @(negedge clk);
    raise(0, 32'h8002_0000);
    exp_q.push_back(32'h8000_8000);
    expect_ack("neg_two", 0, 1'b0, cyc);

    // div_done while idle must be ignored.
    @(negedge clk);
    spur = 1;
    repeat (3) @(negedge clk);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_ack", 64'(ack), 64'd0);

    // Divider that never answers: watchdog abort, then normal service.
    stub = 1;
    rstn_low_cnt = 0;
    raise(1, 32'h0003_0000);
    exp_q.push_back(SAT_POS);
    expect_ack("timeout", 1, 1'b1, cyc);
    chk("timeout_rst_low", 64'(rstn_low_cnt), 64'd2);
    stub = 0;
    @(negedge clk);
    raise(2, 32'h0002_0000);
    exp_q.push_back(32'h0000_8000);
    expect_ack("after_abort", 2, 1'b0, cyc);

    // Two zero operands back to back: acks 3 cycles apart.
    @(negedge clk);
    raise(0, 32'h0000_0000);
    raise(1, 32'h0000_0000);
    exp_q.push_back(SAT_POS);
    expect_ack("zero_a", 0, 1'b1, cyc);
    exp_q.push_back(SAT_POS);
    expect_ack("zero_b", 1, 1'b1, cyc);
    chk("zero_spacing", 64'(cyc), 64'd3);

    // Reset mid-WAIT (ptr=2 so req[3] is in service), req[1] pending.
    @(negedge clk);
    raise(3, 32'h0001_0000);
    raise(1, 32'h0004_0000);
    repeat (4) @(negedge clk);
    #2 assert_rst();
    #1;
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_div_in", 64'(div_in), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_div_rst_n", 64'(div_rst_n), 64'd0);
    repeat (3) @(negedge clk);
    chk("arst_ack", 64'(ack), 64'd0);
    #2 rst = 1'b1;
    exp_q.push_back(32'h0000_4000);
    expect_ack("arst_ptr0", 1, 1'b0, cyc);
    exp_q.push_back(32'h0001_0000);
    expect_ack("arst_then3", 3, 1'b0, cyc);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
